// File: rtl/im_loader.sv
// Instruction-memory loader: receives a byte stream, packs big-endian 32-bit
// words and writes them to IM while holding the core in reset.
module im_loader #(
  parameter int ADDR_W      = 11,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] imaddr_d4,
  output logic [31:0]       imdin,
  output logic              imwe,
  output logic              imce,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold
);

  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [ADDR_W:0]  DEPTH    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] word_idx, word_last;
  logic [1:0]        byte_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [23:0]       asm_q;
  logic [ADDR_W:0]   n_clamp;
  logic              xfer;

  always_comb begin
    n_clamp   = (word_count > DEPTH) ? DEPTH : word_count;
    rx_ready  = (state == RECV);
    imwe      = (state == WRITE);
    imce      = (state == WRITE);
    busy      = (state != IDLE);
    done      = (state == DONE);
    err       = (state == ERR);
    xfer      = rx_valid && (state == RECV);
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (n_clamp == '0) ? DONE : RECV;
      RECV: begin
        if (xfer) begin
          if (byte_cnt == 2'd3) state_nxt = WRITE;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = ERR;
        end
      end
      WRITE: state_nxt = (word_idx == word_last) ? DONE : RECV;
      DONE:  state_nxt = IDLE;
      ERR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The fourth byte loads imdin/imaddr_d4 directly so both hold steady
  // outside WRITE; earlier bytes accumulate in asm_q.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      word_idx  <= '0;
      word_last <= '0;
      byte_cnt  <= '0;
      tmo_cnt   <= '0;
      asm_q     <= '0;
      imaddr_d4 <= '0;
      imdin     <= '0;
      cpu_hold  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            word_last <= n_clamp[ADDR_W-1:0] - ADDR_W'(1);
            word_idx  <= '0;
            byte_cnt  <= '0;
            tmo_cnt   <= '0;
            cpu_hold  <= 1'b1;
          end
        end
        RECV: begin
          if (xfer) begin
            tmo_cnt  <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            asm_q    <= {asm_q[15:0], rx_data};
            if (byte_cnt == 2'd3) begin
              imdin     <= {asm_q, rx_data};
              imaddr_d4 <= word_idx;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        WRITE: begin
          tmo_cnt <= '0;
          if (word_idx != word_last) word_idx <= word_idx + ADDR_W'(1);
        end
        DONE: cpu_hold <= 1'b0;
        ERR:  byte_cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: a word-level model derived from the byte stream is
// compared against every IM write, with directed scenarios around it.
module tb_im_loader;

  localparam int AW    = 4;
  localparam int TMO   = 20;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   wc = '0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready, imwe, imce, busy, done, err, cpu_hold;
  logic [AW-1:0] imaddr;
  logic [31:0]   imdin;

  im_loader #(.ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .start(start), .word_count(wc),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imaddr_d4(imaddr), .imdin(imdin), .imwe(imwe), .imce(imce),
    .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0]     tx_q[$];
  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] wr_log[$];
  int done_cnt = 0, err_cnt = 0;
  logic [AW-1:0] last_addr = '0;
  logic [31:0]   last_data = '0;
  int byte_ctr = 0, idle_run = 0;
  bit prev_fourth = 0, prev_we = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Model: each complete group of four sent bytes is one word, up to min(count, depth).
  task automatic expect_words(input int n_req);
    int n, nw;
    n  = (n_req > DEPTH) ? DEPTH : n_req;
    nw = tx_q.size() / 4;
    if (nw > n) nw = n;
    exp_q.delete();
    for (int w = 0; w < nw; w++)
      exp_q.push_back({AW'(w), tx_q[4*w], tx_q[4*w+1], tx_q[4*w+2], tx_q[4*w+3]});
  endtask

  always @(negedge clk) begin
    logic [AW+31:0] e;
    bit xfer;
    if (!rst_n) begin
      last_addr = '0; last_data = '0; byte_ctr = 0;
      prev_fourth = 0; prev_we = 0; idle_run = 0;
    end else begin
      xfer = rx_valid && rx_ready;
      if (prev_fourth) check("latency_we", imwe, 1);
      if (prev_we && exp_q.size() > 0) check("latency_resume", rx_ready, 1);
      if (imwe) begin
        check("write_ce", imce, 1);
        check("write_no_rx", rx_ready, 0);
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got addr %0h data %0h, no write expected", imaddr, imdin);
        end else begin
          e = exp_q.pop_front();
          if ({imaddr, imdin} !== e) begin
            n_fail++;
            $display("FAIL write: got %0h/%0h expected %0h/%0h", imaddr, imdin, e[AW+31:32], e[31:0]);
          end
        end
        wr_log.push_back({imaddr, imdin});
        last_addr = imaddr;
        last_data = imdin;
      end else begin
        check("idle_ce", imce, 0);
        check("hold_addr", imaddr, last_addr);
        check("hold_data", imdin, last_data);
      end
      if (busy) check("cpu_hold_busy", cpu_hold, 1);
      if (done) begin done_cnt++; check("done_all_written", exp_q.size(), 0); end
      if (err)  begin err_cnt++;  check("err_after_idle", idle_run, TMO); end
      if (rx_ready && !xfer) idle_run++; else idle_run = 0;
      if (xfer) byte_ctr++;
      prev_fourth = xfer && (byte_ctr % 4 == 0);
      if (!busy) byte_ctr = 0;
      prev_we = imwe;
    end
  end

  task automatic do_start(input int n);
    @(posedge clk); #1; start = 1'b1; wc = n[AW:0];
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic send(input int first, input int cnt, input bit gaps);
    int i, cyc, zr;
    i = first; cyc = 0; zr = 0;
    while (i < first + cnt && cyc < 2000) begin
      @(posedge clk); #1;
      rx_data = tx_q[i];
      if (gaps && zr < 3 && $urandom_range(0, 1) == 0) begin rx_valid = 1'b0; zr++; end
      else begin rx_valid = 1'b1; zr = 0; end
      @(negedge clk);
      if (rx_valid && rx_ready) i++;
      cyc++;
    end
    @(posedge clk); #1; rx_valid = 1'b0;
    if (i < first + cnt) begin
      n_tests++; n_fail++;
      $display("FAIL send_budget: sent %0d of %0d bytes", i - first, cnt);
    end
  endtask

  task automatic wait_end(input int budget);
    int c, ev0;
    c = 0; ev0 = done_cnt + err_cnt;
    while (done_cnt + err_cnt == ev0 && c < budget) begin @(posedge clk); c++; end
    if (done_cnt + err_cnt == ev0) begin
      n_tests++; n_fail++;
      $display("FAIL wait_end: no done/err within %0d cycles", budget);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"}, rx_ready, 0);
    check({tag, "_imwe"}, imwe, 0);
    check({tag, "_imce"}, imce, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_imaddr"}, imaddr, 0);
    check({tag, "_imdin"}, imdin, 0);
    check({tag, "_cpu_hold"}, cpu_hold, 1);
  endtask

  task automatic rand_bytes(input int n);
    tx_q.delete();
    for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
  endtask

  initial begin
    int d0, e0, w0;
    #12 check_reset_vals("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Two-word load, back-to-back stream
    tx_q = '{8'h3C, 8'h01, 8'h00, 8'h01, 8'h08, 8'h00, 8'h00, 8'h05};
    expect_words(2);
    check("model_w0", exp_q[0], {AW'(0), 32'h3C010001});
    check("model_w1", exp_q[1], {AW'(1), 32'h08000005});
    d0 = done_cnt; w0 = wr_log.size();
    do_start(2);
    send(0, 8, 0);
    wait_end(50);
    check("t1_done", done_cnt - d0, 1);
    check("t1_nwr", wr_log.size() - w0, 2);
    check("t1_wr0", wr_log[w0], {AW'(0), 32'h3C010001});
    check("t1_wr1", wr_log[w0+1], {AW'(1), 32'h08000005});
    @(negedge clk);
    check("t1_hold", cpu_hold, 0);
    check("t1_busy", busy, 0);

    // Zero-word load
    tx_q.delete(); expect_words(0);
    d0 = done_cnt; w0 = wr_log.size();
    do_start(0);
    @(negedge clk);
    check("t2_done_hi", done, 1);
    @(negedge clk);
    check("t2_done_lo", done, 0);
    check("t2_hold", cpu_hold, 0);
    check("t2_ndone", done_cnt - d0, 1);
    check("t2_nwr", wr_log.size() - w0, 0);

    // Nine words with a gappy valid
    rand_bytes(36); expect_words(9);
    d0 = done_cnt; w0 = wr_log.size();
    do_start(9);
    send(0, 36, 1);
    wait_end(100);
    check("t3_done", done_cnt - d0, 1);
    check("t3_nwr", wr_log.size() - w0, 9);
    check("t3_last_addr", wr_log[wr_log.size()-1][AW+31:32], 8);

    // Timeout after a partial word
    rand_bytes(2); expect_words(3);
    e0 = err_cnt; d0 = done_cnt; w0 = wr_log.size();
    do_start(3);
    send(0, 2, 0);
    wait_end(TMO + 20);
    check("t4_err", err_cnt - e0, 1);
    check("t4_done", done_cnt - d0, 0);
    check("t4_nwr", wr_log.size() - w0, 0);
    @(negedge clk);
    check("t4_busy", busy, 0);
    check("t4_hold", cpu_hold, 1);

    // Reset in the middle of a 16-word load
    rand_bytes(20); expect_words(16);
    e0 = err_cnt; d0 = done_cnt;
    do_start(16);
    send(0, 20, 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    check("t5_written", exp_q.size(), 0);
    check("t5_no_ev", (done_cnt - d0) + (err_cnt - e0), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rand_bytes(4); expect_words(1);
    d0 = done_cnt; w0 = wr_log.size();
    do_start(1);
    send(0, 4, 0);
    wait_end(50);
    check("t5_restart_done", done_cnt - d0, 1);
    check("t5_restart_addr", wr_log[w0][AW+31:32], 0);

    // Oversized count clamps to full depth; a start while busy is ignored
    rand_bytes(4 * DEPTH); expect_words(DEPTH + 5);
    d0 = done_cnt; w0 = wr_log.size();
    do_start(DEPTH + 5);
    @(posedge clk); #1; start = 1'b1; wc = 1;
    @(posedge clk); #1; start = 1'b0;
    send(0, 4 * DEPTH, 0);
    wait_end(200);
    check("t6_done", done_cnt - d0, 1);
    check("t6_nwr", wr_log.size() - w0, DEPTH);
    check("t6_last_addr", wr_log[wr_log.size()-1][AW+31:32], DEPTH - 1);
    repeat (3) @(posedge clk);
    check("t6_extra", wr_log.size() - w0, DEPTH);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
